// File: rtl/alu_core.sv
// Registered integer ALU for the execute stage: arithmetic, single-bit shifts and
// bitwise logic with O/S/C/Z flags, all presented one clock after OP/A/B are sampled.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] RES,
    output logic             O,
    output logic             S,
    output logic             C,
    output logic             Z
);
    localparam logic [4:0] OP_ADD      = 5'b00000;
    localparam logic [4:0] OP_ADDINC   = 5'b00001;
    localparam logic [4:0] OP_INCA     = 5'b00011;
    localparam logic [4:0] OP_SUBDEC   = 5'b00100;
    localparam logic [4:0] OP_SUB      = 5'b00101;
    localparam logic [4:0] OP_DECA     = 5'b00110;
    localparam logic [4:0] OP_LSL      = 5'b01000;
    localparam logic [4:0] OP_ASR      = 5'b01001;
    localparam logic [4:0] OP_ZEROS    = 5'b10000;
    localparam logic [4:0] OP_AND      = 5'b10001;
    localparam logic [4:0] OP_ANDNOTA  = 5'b10010;
    localparam logic [4:0] OP_PASSB    = 5'b10011;
    localparam logic [4:0] OP_ANDNOTB  = 5'b10100;
    localparam logic [4:0] OP_PASSA    = 5'b10101;
    localparam logic [4:0] OP_XOR      = 5'b10110;
    localparam logic [4:0] OP_OR       = 5'b10111;
    localparam logic [4:0] OP_NAND     = 5'b11000;
    localparam logic [4:0] OP_XNOR     = 5'b11001;
    localparam logic [4:0] OP_PASSNOTA = 5'b11010;
    localparam logic [4:0] OP_ORNOTA   = 5'b11011;
    localparam logic [4:0] OP_PASSNOTB = 5'b11100;
    localparam logic [4:0] OP_ORNOTB   = 5'b11101;
    localparam logic [4:0] OP_NOR      = 5'b11110;
    localparam logic [4:0] OP_ONES     = 5'b11111;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             add_ovf;

    logic [WIDTH-1:0] res_d, res_q;
    logic             o_d, o_q;
    logic             s_d, s_q;
    logic             c_d, c_q;
    logic             z_d, z_q;

    // One shared adder: every arithmetic opcode is A + add_b + add_cin.
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case (OP)
            OP_ADD:    add_b = B;
            OP_ADDINC: begin add_b = B;  add_cin = 1'b1; end
            OP_INCA:   add_cin = 1'b1;
            OP_SUBDEC: add_b = ~B;
            OP_SUB:    begin add_b = ~B; add_cin = 1'b1; end
            OP_DECA:   add_b = '1;
            default:   add_b = '0;
        endcase
    end

    assign sum     = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_ovf = (A[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

    always_comb begin
        res_d = '0;
        o_d   = 1'b0;
        c_d   = 1'b0;
        case (OP)
            OP_ADD, OP_ADDINC, OP_INCA, OP_SUBDEC, OP_SUB, OP_DECA: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                o_d   = add_ovf;
            end
            OP_LSL: begin
                res_d = {A[WIDTH-2:0], 1'b0};
                c_d   = A[WIDTH-1];
            end
            OP_ASR: begin
                res_d = {A[WIDTH-1], A[WIDTH-1:1]};
                c_d   = A[0];
            end
            OP_ZEROS:    res_d = '0;
            OP_AND:      res_d = A & B;
            OP_ANDNOTA:  res_d = ~A & B;
            OP_PASSB:    res_d = B;
            OP_ANDNOTB:  res_d = A & ~B;
            OP_PASSA:    res_d = A;
            OP_XOR:      res_d = A ^ B;
            OP_OR:       res_d = A | B;
            OP_NAND:     res_d = ~(A & B);
            OP_XNOR:     res_d = ~(A ^ B);
            OP_PASSNOTA: res_d = ~A;
            OP_ORNOTA:   res_d = ~A | B;
            OP_PASSNOTB: res_d = ~B;
            OP_ORNOTB:   res_d = A | ~B;
            OP_NOR:      res_d = ~(A | B);
            OP_ONES:     res_d = '1;
            default:     res_d = '0;
        endcase
        // Undefined opcodes fall through with RES=0, so Z comes out set naturally.
        s_d = res_d[WIDTH-1];
        z_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= '0;
            o_q   <= 1'b0;
            s_q   <= 1'b0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            res_q <= res_d;
            o_q   <= o_d;
            s_q   <= s_d;
            c_q   <= c_d;
            z_q   <= z_d;
        end
    end

    assign RES = res_q;
    assign O   = o_q;
    assign S   = s_q;
    assign C   = c_q;
    assign Z   = z_q;
endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed vectors with hand-derived expectations, then random
// operations (with occasional resets) checked against an arithmetic reference model.
module tb_alu_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  OP = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] RES;
    logic        O, S, C, Z;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;
    vec_t dir_q[$];

    alu_core #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .OP(OP), .A(A), .B(B),
        .RES(RES), .O(O), .S(S), .C(C), .Z(Z)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: returns {res, O, S, C, Z} from plain integer arithmetic.
    function automatic logic [35:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ur = 0;
        longint sr = 0;
        logic [31:0] r = '0;
        logic o = 1'b0;
        logic c = 1'b0;
        bit arith = 1'b0;
        bit is_sub = 1'b0;
        case (op)
            5'b00000: begin arith = 1; ur = ua + ub;     sr = sa + sb;     end
            5'b00001: begin arith = 1; ur = ua + ub + 1; sr = sa + sb + 1; end
            5'b00011: begin arith = 1; ur = ua + 1;      sr = sa + 1;      end
            5'b00100: begin arith = 1; is_sub = 1; ur = ua - ub - 1; sr = sa - sb - 1; end
            5'b00101: begin arith = 1; is_sub = 1; ur = ua - ub;     sr = sa - sb;     end
            5'b00110: begin arith = 1; is_sub = 1; ur = ua - 1;      sr = sa - 1;      end
            5'b01000: begin r = a << 1; c = a[31]; end
            5'b01001: begin r = 32'($signed(a) >>> 1); c = a[0]; end
            5'b10000: r = 32'h0;
            5'b10001: r = a & b;
            5'b10010: r = ~a & b;
            5'b10011: r = b;
            5'b10100: r = a & ~b;
            5'b10101: r = a;
            5'b10110: r = a ^ b;
            5'b10111: r = a | b;
            5'b11000: r = ~(a & b);
            5'b11001: r = ~(a ^ b);
            5'b11010: r = ~a;
            5'b11011: r = ~a | b;
            5'b11100: r = ~b;
            5'b11101: r = a | ~b;
            5'b11110: r = ~(a | b);
            5'b11111: r = 32'hFFFF_FFFF;
            default:  r = 32'h0;
        endcase
        if (arith) begin
            r = ur[31:0];
            c = is_sub ? (ur >= 0) : (ur > 64'sd4294967295);
            o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        return {r, o, r[31], c, (r == 32'h0)};
    endfunction

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] fl);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl;
        dir_q.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        reset = rst; OP = op; A = a; B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [35:0] exp;
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        string tag;

        // Reset with ONES on the inputs must still give all-zero outputs.
        apply(1'b1, 5'b11111, 32'd1, 32'd2);
        check("reset res", RES, 32'h0);
        check("reset flags", {O, S, C, Z}, 4'b0000);

        // Directed vectors, applied back to back; flags are {O,S,C,Z}.
        add_vec(5'b11111, 32'd1, 32'd2, 32'hFFFF_FFFF, 4'b0100);
        add_vec(5'b01000, 32'd1, 32'd2, 32'h2,         4'b0000);
        add_vec(5'b01001, 32'd1, 32'd2, 32'h0,         4'b0011);
        add_vec(5'b01001, 32'h8000_0001, 32'd2, 32'hC000_0000, 4'b0110);
        add_vec(5'b10000, 32'd1, 32'd2, 32'h0, 4'b0001);
        add_vec(5'b10001, 32'd1, 32'd2, 32'h0, 4'b0001);
        add_vec(5'b10010, 32'd1, 32'd2, 32'h2, 4'b0000);
        add_vec(5'b10011, 32'd1, 32'd2, 32'h2, 4'b0000);
        add_vec(5'b10100, 32'd1, 32'd2, 32'h1, 4'b0000);
        add_vec(5'b10101, 32'd1, 32'd2, 32'h1, 4'b0000);
        add_vec(5'b10110, 32'd1, 32'd2, 32'h3, 4'b0000);
        add_vec(5'b10111, 32'd1, 32'd2, 32'h3, 4'b0000);
        add_vec(5'b11000, 32'd1, 32'd2, 32'hFFFF_FFFF, 4'b0100);
        add_vec(5'b11001, 32'd1, 32'd2, 32'hFFFF_FFFC, 4'b0100);
        add_vec(5'b11010, 32'd1, 32'd2, 32'hFFFF_FFFE, 4'b0100);
        add_vec(5'b11011, 32'd1, 32'd2, 32'hFFFF_FFFE, 4'b0100);
        add_vec(5'b11100, 32'd1, 32'd2, 32'hFFFF_FFFD, 4'b0100);
        add_vec(5'b11101, 32'd1, 32'd2, 32'hFFFF_FFFD, 4'b0100);
        add_vec(5'b11110, 32'd1, 32'd2, 32'hFFFF_FFFC, 4'b0100);
        add_vec(5'b11111, 32'd1, 32'd2, 32'hFFFF_FFFF, 4'b0100);
        add_vec(5'b00000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1100);
        add_vec(5'b00000, 32'hFFFF_FFFF, 32'd1, 32'h0,         4'b0011);
        add_vec(5'b00101, 32'd5, 32'd7, 32'hFFFF_FFFE,         4'b0100);
        add_vec(5'b00101, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b1010);
        add_vec(5'b00101, 32'h1234, 32'h1234, 32'h0,           4'b0011);
        add_vec(5'b01001, 32'h8000_0000, 32'd0, 32'hC000_0000, 4'b0100);
        add_vec(5'b01000, 32'h8000_0000, 32'd0, 32'h0,         4'b0011);
        add_vec(5'b00011, 32'hFFFF_FFFF, 32'd9, 32'h0,         4'b0011);
        add_vec(5'b00110, 32'h0, 32'd9, 32'hFFFF_FFFF,         4'b0100);
        add_vec(5'b00001, 32'd2, 32'd3, 32'd6,                 4'b0000);
        add_vec(5'b00100, 32'd7, 32'd3, 32'd3,                 4'b0010);
        add_vec(5'b00000, 32'd3, 32'd5, 32'd8,                 4'b0000);
        add_vec(5'b10110, 32'd3, 32'd5, 32'd6,                 4'b0000);
        add_vec(5'b01111, 32'd3, 32'd5, 32'd0,                 4'b0001);
        add_vec(5'b01000, 32'd3, 32'd5, 32'd6,                 4'b0000);

        foreach (dir_q[i]) begin
            apply(1'b0, dir_q[i].op, dir_q[i].a, dir_q[i].b);
            tag = $sformatf("dir%0d op%05b res", i, dir_q[i].op);
            check(tag, RES, dir_q[i].res);
            tag = $sformatf("dir%0d op%05b flags", i, dir_q[i].op);
            check(tag, {O, S, C, Z}, dir_q[i].fl);
        end

        // Random operations with corner-biased operands and sporadic resets.
        for (int i = 0; i < 400; i++) begin
            rop = 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h7FFF_FFFF;
                1: ra = 32'h8000_0000;
                2: rb = ra;
                3: rb = 32'hFFFF_FFFF;
                4: ra = 32'h0;
                default: ;
            endcase
            if ($urandom_range(0, 24) == 0) begin
                apply(1'b1, rop, ra, rb);
                check("rand reset res", RES, 32'h0);
                check("rand reset flags", {O, S, C, Z}, 4'b0000);
            end else begin
                apply(1'b0, rop, ra, rb);
                exp = model(rop, ra, rb);
                tag = $sformatf("rand op%05b a%08h b%08h res", rop, ra, rb);
                check(tag, RES, exp[35:4]);
                tag = $sformatf("rand op%05b a%08h b%08h flags", rop, ra, rb);
                check(tag, {O, S, C, Z}, exp[3:0]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
